// File: rtl/doodle_pkg.sv
// Shared definitions for the doodle motion blocks (FSM, renderer, collision).
package doodle_pkg;

  localparam int POS_W_D   = 10;
  localparam int SCORE_W_D = 16;
  localparam int Y_MAX_D   = 1000;

  // One-hot state encoding; each bit doubles as its state flag.
  typedef enum logic [3:0] {
    S_I    = 4'b0001,
    S_UP   = 4'b0010,
    S_DOWN = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  // Height of a spring-boosted arc: twice the requested height, capped at the ceiling.
  function automatic int unsigned spring_j(input int unsigned jin, input int unsigned ymax);
    int unsigned dbl;
    dbl = 2 * jin;
    return (dbl > ymax) ? ymax : dbl;
  endfunction

endpackage

// File: rtl/doodle_score_ctr.sv
// Peak-height tracker with a saturating score counter.
// Score advances once each time Y climbs above the previous peak.
import doodle_pkg::*;

module doodle_score_ctr #(
  parameter int POS_W   = POS_W_D,
  parameter int SCORE_W = SCORE_W_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  input  logic [POS_W-1:0]   new_y,
  output logic [SCORE_W-1:0] score
);

  logic [POS_W-1:0] peak;

  // Peak/score update: clear wins, then a new-high increment.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      peak  <= '0;
      score <= '0;
    end else if (inc && (new_y > peak)) begin
      peak <= new_y;
      if (score != '1) score <= score + 1'b1;
    end
  end

endmodule

// File: rtl/doodle_jump_fsm.sv
// Doodle vertical-motion controller: multi-bounce jump arcs stepped on frame Tick.
// Optional feature macro: DOODLE_SPRING_EN (adds Spring input; spring landings
// double the next arc height, capped at Y_MAX).
import doodle_pkg::*;

module doodle_jump_fsm #(
  parameter int POS_W   = POS_W_D,
  parameter int SCORE_W = SCORE_W_D,
  parameter int Y_MAX   = Y_MAX_D
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic               Tick,
  input  logic [POS_W-1:0]   Jin,
  input  logic               Land,
`ifdef DOODLE_SPRING_EN
  input  logic               Spring,
`endif
  output logic [POS_W-1:0]   J,
  output logic [POS_W-1:0]   Curr,
  output logic [POS_W-1:0]   Y,
  output logic [SCORE_W-1:0] Score,
  output logic               q_I,
  output logic               q_Up,
  output logic               q_Down,
  output logic               q_Done
);

  localparam logic [POS_W-1:0] YMAX_P = POS_W'(Y_MAX);

  state_t           state_q, state_d;
  logic [3:0]       state_bits;
  logic [POS_W-1:0] j_d, curr_d, y_d, j_land;
  logic             inc, clr;

  assign state_bits = state_q;
  assign q_I    = state_bits[0];
  assign q_Up   = state_bits[1];
  assign q_Down = state_bits[2];
  assign q_Done = state_bits[3];

`ifdef DOODLE_SPRING_EN
  assign j_land = Spring ? POS_W'(spring_j(32'(Jin), Y_MAX)) : Jin;
`else
  assign j_land = Jin;
`endif

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_I;
      J       <= '0;
      Curr    <= '0;
      Y       <= '0;
    end else begin
      state_q <= state_d;
      J       <= j_d;
      Curr    <= curr_d;
      Y       <= y_d;
    end
  end

  // Next-state and datapath updates; motion only advances on Tick.
  always_comb begin
    state_d = state_q;
    j_d     = J;
    curr_d  = Curr;
    y_d     = Y;
    inc     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_I: begin
        j_d    = Jin;
        curr_d = '0;
        y_d    = '0;
        clr    = 1'b1;
        if (Start) state_d = S_UP;
      end
      S_UP: if (Tick) begin
        if ((Curr == J) || (Y == YMAX_P)) begin
          state_d = S_DOWN;
        end else begin
          curr_d = Curr + 1'b1;
          y_d    = Y + 1'b1;
          inc    = 1'b1;
        end
      end
      S_DOWN: if (Tick) begin
        // Landing beats the floor check so a bounce at Y==0 keeps the game alive.
        if (Land) begin
          state_d = S_UP;
          j_d     = j_land;
          curr_d  = '0;
        end else if (Y == '0) begin
          state_d = S_DONE;
        end else begin
          y_d    = Y - 1'b1;
          curr_d = (Curr == '0) ? '0 : Curr - 1'b1;
        end
      end
      S_DONE: if (Ack) state_d = S_I;
      default: state_d = S_I;
    endcase
  end

  doodle_score_ctr #(
    .POS_W   (POS_W),
    .SCORE_W (SCORE_W)
  ) u_score (
    .clk   (Clk),
    .reset (Reset),
    .clr   (clr),
    .inc   (inc),
    .new_y (y_d),
    .score (Score)
  );

endmodule

// File: tb/tb_doodle_jump_fsm.sv
// Directed self-checking bench for doodle_jump_fsm.
module tb_doodle_jump_fsm;

  localparam int POS_W   = 10;
  localparam int SCORE_W = 16;

  logic               Clk = 1'b0;
  logic               Reset, Start, Ack, Tick, Land;
  logic               Spring;
  logic [POS_W-1:0]   Jin;
  logic [POS_W-1:0]   J, Curr, Y;
  logic [SCORE_W-1:0] Score;
  logic               q_I, q_Up, q_Down, q_Done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  doodle_jump_fsm #(.POS_W(POS_W), .SCORE_W(SCORE_W), .Y_MAX(1000)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Tick(Tick),
    .Jin(Jin), .Land(Land),
`ifdef DOODLE_SPRING_EN
    .Spring(Spring),
`endif
    .J(J), .Curr(Curr), .Y(Y), .Score(Score),
    .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done)
  );

`ifdef DOODLE_SPRING_EN
  logic [POS_W-1:0]   c_J, c_Curr, c_Y;
  logic [SCORE_W-1:0] c_Score;
  logic               c_I, c_Up, c_Down, c_Done;

  doodle_jump_fsm #(.POS_W(POS_W), .SCORE_W(SCORE_W), .Y_MAX(10)) dut_c (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Tick(Tick),
    .Jin(Jin), .Land(Land), .Spring(Spring),
    .J(c_J), .Curr(c_Curr), .Y(c_Y), .Score(c_Score),
    .q_I(c_I), .q_Up(c_Up), .q_Down(c_Down), .q_Done(c_Done)
  );
`endif

  // One clock edge with Tick driven to t; outputs sampled 1ns after the edge.
  task automatic cyc(input logic t);
    Tick = t;
    @(posedge Clk);
    #1;
    Tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 0; Ack = 0; Tick = 0; Land = 0; Spring = 0; Jin = '0;
    cyc(0); cyc(0);
    n_chk++; if (q_I !== 1'b1) $display("FAIL rst_qi got %b want 1", q_I); else n_pass++;
    n_chk++; if ({J, Curr, Y} !== '0) $display("FAIL rst_regs got J=%0d C=%0d Y=%0d want 0", J, Curr, Y); else n_pass++;
    Reset = 1'b0;
    // enter an arc, then reset mid-climb
    Jin = 10'd5; Start = 1; cyc(0); Start = 0;
    ticks(2);
    n_chk++; if (Y !== 10'd2) $display("FAIL rst_pre_y got %0d want 2", Y); else n_pass++;
    Reset = 1'b1; cyc(0); cyc(0);
    n_chk++; if (q_I !== 1'b1 || q_Up !== 1'b0) $display("FAIL rst_mid_state got I=%b U=%b want I=1 U=0", q_I, q_Up); else n_pass++;
    n_chk++; if ({J, Curr, Y} !== '0 || Score !== '0) $display("FAIL rst_mid_regs got J=%0d C=%0d Y=%0d S=%0d want 0", J, Curr, Y, Score); else n_pass++;
    Reset = 1'b0; Jin = '0;
    cyc(0);
  endtask

  task automatic test_basic_arc;
    Jin = 10'd3; Start = 1; cyc(0); Start = 0;
    n_chk++; if (q_Up !== 1'b1 || J !== 10'd3) $display("FAIL arc_start got U=%b J=%0d want U=1 J=3", q_Up, J); else n_pass++;
    ticks(3);
    n_chk++; if (Y !== 10'd3 || Score !== 16'd3 || Curr !== 10'd3) $display("FAIL arc_climb got Y=%0d S=%0d C=%0d want 3/3/3", Y, Score, Curr); else n_pass++;
    ticks(1);
    n_chk++; if (q_Down !== 1'b1 || Y !== 10'd3) $display("FAIL arc_top got D=%b Y=%0d want D=1 Y=3", q_Down, Y); else n_pass++;
    // no Tick: hold; Ack outside DONE ignored
    Ack = 1; cyc(0); cyc(0); Ack = 0;
    n_chk++; if (q_Down !== 1'b1 || Y !== 10'd3) $display("FAIL arc_hold got D=%b Y=%0d want D=1 Y=3", q_Down, Y); else n_pass++;
    ticks(3);
    n_chk++; if (Y !== 10'd0 || Curr !== 10'd0 || q_Down !== 1'b1) $display("FAIL arc_fall got Y=%0d C=%0d D=%b want 0/0/1", Y, Curr, q_Down); else n_pass++;
    ticks(1);
    n_chk++; if (q_Done !== 1'b1 || Score !== 16'd3) $display("FAIL arc_done got Dn=%b S=%0d want 1/3", q_Done, Score); else n_pass++;
    Ack = 1; cyc(0); Ack = 0;
    n_chk++; if (q_I !== 1'b1) $display("FAIL arc_ack got I=%b want 1", q_I); else n_pass++;
  endtask

  task automatic test_land;
    Jin = 10'd4; Start = 1; cyc(0); Start = 0;
    ticks(4);
    n_chk++; if (Y !== 10'd4) $display("FAIL land_climb got Y=%0d want 4", Y); else n_pass++;
    ticks(3);
    n_chk++; if (Y !== 10'd2 || q_Down !== 1'b1) $display("FAIL land_fall got Y=%0d D=%b want 2/1", Y, q_Down); else n_pass++;
    Land = 1; Jin = 10'd5; ticks(1); Land = 0;
    n_chk++; if (q_Up !== 1'b1 || J !== 10'd5 || Curr !== 10'd0 || Y !== 10'd2) $display("FAIL land_bounce got U=%b J=%0d C=%0d Y=%0d want 1/5/0/2", q_Up, J, Curr, Y); else n_pass++;
    ticks(5);
    n_chk++; if (Y !== 10'd7 || Score !== 16'd7) $display("FAIL land_peak got Y=%0d S=%0d want 7/7", Y, Score); else n_pass++;
  endtask

  task automatic test_land_at_floor;
    ticks(1);
    n_chk++; if (q_Down !== 1'b1) $display("FAIL floor_top got D=%b want 1", q_Down); else n_pass++;
    ticks(7);
    n_chk++; if (Y !== 10'd0 || Curr !== 10'd0) $display("FAIL floor_fall got Y=%0d C=%0d want 0/0", Y, Curr); else n_pass++;
    Land = 1; Jin = 10'd0; ticks(1); Land = 0;
    n_chk++; if (q_Up !== 1'b1 || q_Done !== 1'b0) $display("FAIL floor_land got U=%b Dn=%b want 1/0", q_Up, q_Done); else n_pass++;
    ticks(2);
    n_chk++; if (q_Done !== 1'b1 || Score !== 16'd7) $display("FAIL floor_end got Dn=%b S=%0d want 1/7", q_Done, Score); else n_pass++;
    Ack = 1; cyc(0); Ack = 0;
  endtask

  task automatic test_zero_jump;
    Jin = 10'd0; Start = 1; cyc(0); Start = 0;
    ticks(1);
    n_chk++; if (q_Down !== 1'b1 || Y !== 10'd0) $display("FAIL zero_down got D=%b Y=%0d want 1/0", q_Down, Y); else n_pass++;
    ticks(1);
    n_chk++; if (q_Done !== 1'b1 || Score !== 16'd0) $display("FAIL zero_done got Dn=%b S=%0d want 1/0", q_Done, Score); else n_pass++;
    Start = 1; cyc(0); cyc(1); Start = 0;
    n_chk++; if (q_Done !== 1'b1) $display("FAIL zero_start_ign got Dn=%b want 1", q_Done); else n_pass++;
    Ack = 1; cyc(0); Ack = 0;
    n_chk++; if (q_I !== 1'b1) $display("FAIL zero_ack got I=%b want 1", q_I); else n_pass++;
  endtask

`ifdef DOODLE_SPRING_EN
  task automatic test_spring;
    Jin = 10'd2; Start = 1; cyc(0); Start = 0;
    ticks(3);
    n_chk++; if (q_Down !== 1'b1 || Y !== 10'd2) $display("FAIL spr_pre got D=%b Y=%0d want 1/2", q_Down, Y); else n_pass++;
    Land = 1; Spring = 1; Jin = 10'd6; ticks(1); Land = 0; Spring = 0;
    n_chk++; if (J !== 10'd12 || q_Up !== 1'b1) $display("FAIL spr_j got J=%0d U=%b want 12/1", J, q_Up); else n_pass++;
    n_chk++; if (c_J !== 10'd10) $display("FAIL spr_j_cap got J=%0d want 10", c_J); else n_pass++;
    ticks(8);
    n_chk++; if (c_Y !== 10'd10 || Y !== 10'd10) $display("FAIL spr_climb got cY=%0d Y=%0d want 10/10", c_Y, Y); else n_pass++;
    ticks(1);
    n_chk++; if (c_Down !== 1'b1 || c_Y !== 10'd10) $display("FAIL spr_ceil got D=%b Y=%0d want 1/10", c_Down, c_Y); else n_pass++;
    n_chk++; if (q_Up !== 1'b1 || Y !== 10'd11) $display("FAIL spr_nocap got U=%b Y=%0d want 1/11", q_Up, Y); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_arc();
    test_land();
    test_land_at_floor();
    test_zero_jump();
`ifdef DOODLE_SPRING_EN
    test_spring();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
